// File: rtl/cpu_mem_arbiter.sv
// Merges the core's inst-fetch and data ports onto one shared memory port and steers responses back in order.
// Optional ARB_RR_EN: round-robin between masters instead of fixed DATA-over-INST priority.
`timescale 1ns/1ps

module cpu_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic        OWN_INST = 1'b0;
    localparam logic        OWN_DATA = 1'b1;

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [DEPTH-1:0] r_fifo;
    logic             r_lock;
    logic             r_lock_own;
`ifdef ARB_RR_EN
    logic             r_rr_ptr;
`endif

    logic w_gnt_vld;
    logic w_gnt_own;
    logic w_sel_d;
    logic w_sel_i;
    logic w_m_req;
    logic w_hs;
    logic w_pop;
    logic w_head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant: a stalled request keeps the port; otherwise arbitrate when the owner FIFO has room.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_own = OWN_INST;
        if (r_lock) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = r_lock_own;
        end else if (r_count != CNT_W'(DEPTH)) begin
            if (d_req || i_req) begin
                w_gnt_vld = 1'b1;
`ifdef ARB_RR_EN
                w_gnt_own = (d_req && i_req) ? ~r_rr_ptr : d_req;
`else
                w_gnt_own = d_req;
`endif
            end
        end
    end

    assign w_sel_d = w_gnt_vld & (w_gnt_own == OWN_DATA);
    assign w_sel_i = w_gnt_vld & (w_gnt_own == OWN_INST);
    assign w_m_req = ~reset & ((w_sel_d & d_req) | (w_sel_i & i_req));
    assign w_hs    = w_m_req & m_addr_ok;
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_pop   = ~reset & m_data_ok & (r_count != '0);

    assign m_req   = w_m_req;
    assign m_addr  = w_sel_d ? d_addr : (w_sel_i ? i_addr : '0);
    assign m_wstrb = w_sel_d ? d_wstrb : STRB_W'(0);
    assign m_wdata = w_sel_d ? d_wdata : '0;

    assign i_addr_ok = w_hs & (w_gnt_own == OWN_INST);
    assign d_addr_ok = w_hs & (w_gnt_own == OWN_DATA);
    assign i_data_ok = w_pop & (w_head == OWN_INST);
    assign d_data_ok = w_pop & (w_head == OWN_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    // In-order owner FIFO plus address-phase lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fifo     <= '0;
            r_lock     <= 1'b0;
            r_lock_own <= OWN_INST;
        end else begin
            if (w_hs) begin
                r_fifo[r_wr_ptr] <= w_gnt_own;
                r_wr_ptr         <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_m_req && !m_addr_ok) begin
                r_lock     <= 1'b1;
                r_lock_own <= w_gnt_own;
            end else if (m_addr_ok) begin
                r_lock <= 1'b0;
            end
        end
    end

`ifdef ARB_RR_EN
    // Round-robin pointer remembers the last master to complete a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= OWN_INST;
        end else if (w_hs) begin
            r_rr_ptr <= w_gnt_own;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: master/slave models, in-order response checking, directed scenarios.
`timescale 1ns/1ps

module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_addr_ok, d_data_ok;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_addr_ok, m_data_ok;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    // Pending master requests and expected responses
    logic [31:0] iq_addr[$];
    logic [31:0] dq_addr[$];
    logic [31:0] dq_wdata[$];
    logic [3:0]  dq_wstrb[$];
    logic [31:0] exp_i[$];
    bit          exp_d_rd[$];
    logic [31:0] exp_d_dat[$];
    bit          hs_log[$];
    bit          resp_log[$];

    logic [31:0] sq[$];
    bit          s_en;
    int          s_budget;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h1c000000) ? 32'h02800000 : (a ^ 32'hA5A50000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic put_i(input logic [31:0] a);
        iq_addr.push_back(a);
        exp_i.push_back(mem_rd(a));
    endtask

    task automatic put_d(input logic [3:0] s, input logic [31:0] a, input logic [31:0] w);
        dq_wstrb.push_back(s);
        dq_addr.push_back(a);
        dq_wdata.push_back(w);
        exp_d_rd.push_back(s == 4'h0);
        exp_d_dat.push_back(mem_rd(a));
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Master models: hold each request until its addr_ok is seen
    initial begin : masters
        bit i_acc, d_acc;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wstrb = '0; d_wdata = '0;
        forever begin
            @(negedge clk);
            i_acc = i_addr_ok;
            d_acc = d_addr_ok;
            @(posedge clk);
            #1;
            if (i_acc && iq_addr.size() > 0) void'(iq_addr.pop_front());
            if (d_acc && dq_addr.size() > 0) begin
                void'(dq_addr.pop_front());
                void'(dq_wdata.pop_front());
                void'(dq_wstrb.pop_front());
            end
            i_req   = (iq_addr.size() > 0);
            i_addr  = i_req ? iq_addr[0] : '0;
            d_req   = (dq_addr.size() > 0);
            d_addr  = d_req ? dq_addr[0] : '0;
            d_wdata = d_req ? dq_wdata[0] : '0;
            d_wstrb = d_req ? dq_wstrb[0] : '0;
        end
    end

    // Slave model: 1-cycle latency, responses in order, gated by s_en / s_budget
    initial begin : slave
        bit s_hs, s_cons;
        logic [31:0] s_addr;
        m_data_ok = 1'b0;
        m_rdata   = '0;
        forever begin
            @(negedge clk);
            s_hs   = m_req & m_addr_ok;
            s_addr = m_addr;
            s_cons = m_data_ok;
            @(posedge clk);
            #1;
            if (s_cons && sq.size() > 0) void'(sq.pop_front());
            if (s_hs) sq.push_back(mem_rd(s_addr));
            if ((s_en || s_budget > 0) && sq.size() > 0) begin
                m_data_ok = 1'b1;
                m_rdata   = sq[0];
                if (!s_en) s_budget--;
            end else begin
                m_data_ok = 1'b0;
                m_rdata   = '0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (i_addr_ok || d_addr_ok) begin
            chk("addr_ok_onehot", 32'(i_addr_ok & d_addr_ok), 32'h0);
            hs_log.push_back(d_addr_ok);
        end
        if (i_addr_ok) begin
            chk("i_m_addr", m_addr, i_addr);
            chk("i_m_wstrb", 32'(m_wstrb), 32'h0);
            chk("i_m_wdata", m_wdata, 32'h0);
        end
        if (d_addr_ok) begin
            chk("d_m_addr", m_addr, d_addr);
            chk("d_m_wstrb", 32'(m_wstrb), 32'(d_wstrb));
            chk("d_m_wdata", m_wdata, d_wdata);
        end
        if (i_data_ok || d_data_ok) begin
            chk("data_ok_onehot", 32'(i_data_ok & d_data_ok), 32'h0);
            resp_log.push_back(d_data_ok);
        end
        if (i_data_ok) begin
            if (exp_i.size() == 0) chk("i_unexpected_data_ok", 32'(i_data_ok), 32'h0);
            else chk("i_rdata", i_rdata, exp_i.pop_front());
        end
        if (d_data_ok) begin
            if (exp_d_rd.size() == 0) chk("d_unexpected_data_ok", 32'(d_data_ok), 32'h0);
            else begin
                logic [31:0] e;
                e = exp_d_dat.pop_front();
                if (exp_d_rd.pop_front()) chk("d_rdata", d_rdata, e);
            end
        end
    end

    // A held request must keep the port and its fields while m_addr_ok stays low
    task automatic lock_test(input bit first_d, input logic [31:0] a1, input logic [31:0] a2);
        m_addr_ok = 1'b0;
        if (first_d) put_d(4'hF, a1, 32'hCAFEF00D);
        else         put_i(a1);
        cyc();
        if (first_d) put_i(a2);
        else         put_d(4'h0, a2, 32'h0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("lock_m_req", 32'(m_req), 32'h1);
            chk("lock_m_addr", m_addr, a1);
            chk("lock_m_wstrb", 32'(m_wstrb), first_d ? 32'hF : 32'h0);
            chk("lock_other_addr_ok", 32'(first_d ? i_addr_ok : d_addr_ok), 32'h0);
            cyc();
        end
        m_addr_ok = 1'b1;
        mid();
        chk("lock_first_ok", 32'(first_d ? d_addr_ok : i_addr_ok), 32'h1);
        cyc();
        mid();
        chk("lock_second_ok", 32'(first_d ? i_addr_ok : d_addr_ok), 32'h1);
        cyc();
        repeat (3) cyc();
    endtask

    initial begin : main
        bit exp_seq[6];
        reset = 1'b1; m_addr_ok = 1'b1; s_en = 1'b1; s_budget = 0;

        // Reset state: request pending but everything held low
        put_i(32'h1c000000);
        repeat (3) cyc();
        mid();
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_i_addr_ok", 32'(i_addr_ok), 32'h0);
        chk("rst_i_data_ok", 32'(i_data_ok), 32'h0);

        // Single inst fetch, zero-latency accept, data one cycle later
        cyc();
        reset = 1'b0;
        mid();
        chk("t1_i_addr_ok", 32'(i_addr_ok), 32'h1);
        chk("t1_d_data_ok_a", 32'(d_data_ok), 32'h0);
        cyc();
        mid();
        chk("t1_i_data_ok", 32'(i_data_ok), 32'h1);
        chk("t1_i_rdata", i_rdata, 32'h02800000);
        chk("t1_d_data_ok_b", 32'(d_data_ok), 32'h0);
        cyc();

        // Simultaneous requests: DATA first, responses follow issue order
        hs_log.delete(); resp_log.delete();
        put_d(4'hF, 32'h8000, 32'h12345678);
        put_i(32'h1c000004);
        repeat (6) cyc();
        chk("t2_hs_cnt", hs_log.size(), 32'd2);
        chk("t2_resp_cnt", resp_log.size(), 32'd2);
        if (hs_log.size() >= 2 && resp_log.size() >= 2) begin
            chk("t2_hs0_data", 32'(hs_log[0]), 32'h1);
            chk("t2_hs1_inst", 32'(hs_log[1]), 32'h0);
            chk("t2_resp0_data", 32'(resp_log[0]), 32'h1);
            chk("t2_resp1_inst", 32'(resp_log[1]), 32'h0);
        end

        // Stalled address phase: DATA held, then INST held
        lock_test(1'b1, 32'h8000, 32'h1c000008);
        lock_test(1'b0, 32'h1c00000c, 32'h8004);

        // Full owner FIFO: two issues, then one pop allows exactly one more
        m_addr_ok = 1'b1; s_en = 1'b0;
        hs_log.delete();
        put_d(4'h0, 32'h100, 32'h0);
        put_d(4'h0, 32'h104, 32'h0);
        put_i(32'h200);
        put_i(32'h204);
        repeat (5) cyc();
        mid();
        chk("t4_hs_cnt_full", hs_log.size(), 32'd2);
        chk("t4_m_req_full", 32'(m_req), 32'h0);
        cyc();
        s_budget = 1;
        cyc();
        mid();
        chk("t4_pop_data_ok", 32'(i_data_ok | d_data_ok), 32'h1);
        chk("t4_pop_m_req", 32'(m_req), 32'h0);
        cyc();
        mid();
        chk("t4_reissue_m_req", 32'(m_req), 32'h1);
        cyc();
        mid();
        chk("t4_refull_m_req", 32'(m_req), 32'h0);
        chk("t4_hs_cnt", hs_log.size(), 32'd3);
        cyc();
        s_en = 1'b1;
        repeat (8) cyc();

        // Reset with two outstanding: late responses are dropped
        s_en = 1'b0;
        put_i(32'h300);
        put_d(4'h0, 32'h304, 32'h0);
        repeat (4) cyc();
        reset = 1'b1;
        exp_i.delete(); exp_d_rd.delete(); exp_d_dat.delete();
        cyc();
        reset = 1'b0;
        s_budget = 2;
        cyc();
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("t5_m_data_ok_seen", 32'(m_data_ok), 32'h1);
            chk("t5_i_data_ok_drop", 32'(i_data_ok), 32'h0);
            chk("t5_d_data_ok_drop", 32'(d_data_ok), 32'h0);
            cyc();
        end
        hs_log.delete();
        put_i(32'h400);
        put_i(32'h404);
        put_i(32'h408);
        repeat (5) cyc();
        chk("t5_post_rst_hs", hs_log.size(), 32'd2);
        s_en = 1'b1;
        repeat (8) cyc();

        // Both masters requesting every cycle
        hs_log.delete();
        put_d(4'hF, 32'h600, 32'h11); put_i(32'h700);
        put_d(4'hF, 32'h604, 32'h22); put_i(32'h704);
        put_d(4'hF, 32'h608, 32'h33); put_i(32'h708);
`ifdef ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        repeat (10) cyc();
        chk("t6_hs_cnt", hs_log.size(), 32'd6);
        if (hs_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("t6_grant%0d", k), 32'(hs_log[k]), 32'(exp_seq[k]));
        end

        // Drain and confirm every expected response arrived
        for (int k = 0; k < 50 && (exp_i.size() > 0 || exp_d_rd.size() > 0); k++) cyc();
        chk("end_exp_i_left", exp_i.size(), 32'd0);
        chk("end_exp_d_left", exp_d_rd.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
